pulse_gen: RTL and testbench

Programmable pulse-train generator: on a start command it drives `d_out` through N high/low periods of programmable length, then reports completion. It is the transmit-side counterpart of the edge detector: it produces the level transitions that the edge detector consumes. It also flags its own edges, so a bench can check a detector against ground truth. It sits between control logic (or a test harness) and any single-bit level consumer.

---
 rtl/pulse_gen_pkg.sv | 15 +
 rtl/phase_counter.sv | 32 +++
 rtl/pulse_gen.sv | 165 ++++++++++++++++
 tb/tb_pulse_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse-train generator.
// Holds the FSM state encoding and the default counter widths.
// No logic; imported by the top and the counter sub-module.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 8;
    localparam int NUM_W_DEFAULT = 8;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter whose last flag marks the final cycle of a span.
// Latency: load/decrement take effect at the next rising edge.
// No backpressure; it saturates at zero instead of wrapping.
module phase_counter
    import pulse_gen_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] count;

    // Load has priority over decrement; never step below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: N pulses of H high / L low cycles.
// Latency: first high cycle follows the accepting edge; all outputs registered.
// No backpressure; start is ignored while busy, abort ends a train next cycle.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int NUM_W = NUM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    input  logic             abort,
    output logic             d_out,
    output logic             busy,
    output logic             done,
    output logic             rise_edge,
    output logic             fall_edge
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;

    // Phase lengths captured at start; zero lengths become one cycle.
    logic [CNT_W-1:0] h_len, l_len;
    logic             len_latch;

    logic             ph_load, ph_dec, ph_last;
    logic [CNT_W-1:0] ph_val;
    logic             np_load, np_dec, np_last;

    logic d_out_nxt, busy_nxt, done_nxt, rise_nxt, fall_nxt;

    logic [CNT_W-1:0] high_sat, low_sat;
    assign high_sat = (high_len == '0) ? ONE : high_len;
    assign low_sat  = (low_len  == '0) ? ONE : low_len;

    phase_counter #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .last     (ph_last)
    );

    phase_counter #(.W(NUM_W)) u_pulse_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (np_load),
        .load_val (num_pulses),
        .dec      (np_dec),
        .last     (np_last)
    );

    // State, latched lengths and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            h_len     <= ONE;
            l_len     <= ONE;
            d_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rise_edge <= 1'b0;
            fall_edge <= 1'b0;
        end else begin
            state     <= state_nxt;
            d_out     <= d_out_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rise_edge <= rise_nxt;
            fall_edge <= fall_nxt;
            if (len_latch) begin
                h_len <= high_sat;
                l_len <= low_sat;
            end
        end
    end

    // Next state, counter controls and next output values.
    always_comb begin
        state_nxt = state;
        d_out_nxt = d_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        len_latch = 1'b0;
        ph_load   = 1'b0;
        ph_dec    = 1'b0;
        ph_val    = h_len;
        np_load   = 1'b0;
        np_dec    = 1'b0;

        unique case (state)
            IDLE: begin
                // abort wins over a coincident start
                if (start && !abort) begin
                    if (num_pulses != '0) begin
                        len_latch = 1'b1;
                        ph_load   = 1'b1;
                        ph_val    = high_sat;
                        np_load   = 1'b1;
                        state_nxt = HIGH;
                        d_out_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                        rise_nxt  = 1'b1;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_nxt = IDLE;
                    d_out_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    fall_nxt  = d_out;
                end else if (ph_last) begin
                    state_nxt = LOW;
                    ph_load   = 1'b1;
                    ph_val    = l_len;
                    d_out_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    ph_dec    = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    state_nxt = IDLE;
                    d_out_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    fall_nxt  = d_out;
                end else if (ph_last) begin
                    if (np_last) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = HIGH;
                        ph_load   = 1'b1;
                        ph_val    = h_len;
                        np_dec    = 1'b1;
                        d_out_nxt = 1'b1;
                        rise_nxt  = 1'b1;
                    end
                end else begin
                    ph_dec    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                d_out_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen with a registered edge detector on d_out.
module tb_pulse_gen;
    import pulse_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] high_len, low_len, num_pulses;
    logic       abort;
    logic       d_out, busy, done, rise_edge, fall_edge;

    int n_cmp = 0;
    int n_err = 0;

    // loopback edge detector (registers d_out, reports edges one cycle later)
    logic d_q, det_rise, det_fall;

    pulse_gen #(.CNT_W(8), .NUM_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
        .abort      (abort),
        .d_out      (d_out),
        .busy       (busy),
        .done       (done),
        .rise_edge  (rise_edge),
        .fall_edge  (fall_edge)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            d_q      <= 1'b0;
            det_rise <= 1'b0;
            det_fall <= 1'b0;
        end else begin
            d_q      <= d_out;
            det_rise <= d_out & ~d_q;
            det_fall <= ~d_out & d_q;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, d_out, busy, done, rise_edge, fall_edge}, {27'd0, exp});
    endtask

    logic [14:0] pat15;
    logic [5:0]  pat6;
    logic [3:0]  pat4;
    logic        saw_done, saw_high, got_done;
    logic        p_r, p_f;
    int          h, l, n, rises;

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        high_len = 8'd3; low_len = 8'd3; num_pulses = 8'd2;

        // reset held with start asserted
        tick(); outs("reset_c1", 5'b00000);
        tick(); outs("reset_c2", 5'b00000);
        rst = 1'b0; start = 1'b0;
        tick(); outs("post_reset_c1", 5'b00000);
        tick(); outs("post_reset_c2", 5'b00000);

        // basic train H=2 L=3 N=3
        high_len = 8'd2; low_len = 8'd3; num_pulses = 8'd3; start = 1'b1;
        tick(); start = 1'b0;
        pat15 = 15'b110001100011000;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("basic_d_out_%0d", i), {31'd0, d_out}, {31'd0, pat15[14-i]});
            chk($sformatf("basic_rise_%0d", i), {31'd0, rise_edge}, {31'd0, (i == 0 || i == 5 || i == 10)});
            chk($sformatf("basic_fall_%0d", i), {31'd0, fall_edge}, {31'd0, (i == 2 || i == 7 || i == 12)});
            chk($sformatf("basic_busy_%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("basic_done_%0d", i), {31'd0, done}, 32'd0);
            tick();
        end
        outs("basic_done_cycle", 5'b00100);
        tick(); outs("basic_after_done", 5'b00000);

        // zero pulses: done next cycle, no activity
        high_len = 8'd2; low_len = 8'd2; num_pulses = 8'd0; start = 1'b1;
        tick(); start = 1'b0;
        outs("zero_n_done", 5'b00100);
        saw_high = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (d_out || busy || done) saw_high = 1'b1;
        end
        chk("zero_n_quiet", {31'd0, saw_high}, 32'd0);

        // zero lengths treated as one: 1010
        high_len = 8'd0; low_len = 8'd0; num_pulses = 8'd2; start = 1'b1;
        tick(); start = 1'b0;
        pat4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("zero_len_d_out_%0d", i), {31'd0, d_out}, {31'd0, pat4[3-i]});
            tick();
        end
        outs("zero_len_done", 5'b00100);
        tick();

        // abort in the 2nd high cycle
        high_len = 8'd4; low_len = 8'd4; num_pulses = 8'd5; start = 1'b1;
        tick(); start = 1'b0;
        outs("abort_hi1", 5'b11010);
        tick();
        outs("abort_hi2", 5'b11000);
        abort = 1'b1;
        tick(); abort = 1'b0;
        outs("abort_next", 5'b00001);
        saw_done = 1'b0; saw_high = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) saw_done = 1'b1;
            if (d_out || busy) saw_high = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        chk("abort_stays_idle", {31'd0, saw_high}, 32'd0);

        // back-to-back: first train H=1 L=2 N=1
        high_len = 8'd1; low_len = 8'd2; num_pulses = 8'd1; start = 1'b1;
        tick(); start = 1'b0;
        outs("b2b_a_c1", 5'b11010);
        tick(); outs("b2b_a_c2", 5'b01001);
        tick(); outs("b2b_a_c3", 5'b01000);
        tick(); outs("b2b_a_done", 5'b00100);
        // start in the done cycle: H=2 L=1 N=2 -> 110110
        high_len = 8'd2; low_len = 8'd1; num_pulses = 8'd2; start = 1'b1;
        tick(); start = 1'b0;
        pat6 = 6'b110110;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b2b_b_d_out_%0d", i), {31'd0, d_out}, {31'd0, pat6[5-i]});
            chk($sformatf("b2b_b_busy_%0d", i), {31'd0, busy}, 32'd1);
            // mid-train start with different parameters must be ignored
            if (i == 1) begin
                start = 1'b1; high_len = 8'd9; low_len = 8'd9; num_pulses = 8'd9;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        outs("b2b_b_done", 5'b00100);
        tick(); outs("b2b_b_idle", 5'b00000);

        // loopback against the registered edge detector, random trains
        for (int t = 0; t < 4; t++) begin
            h = $urandom_range(1, 15);
            l = $urandom_range(1, 15);
            n = $urandom_range(1, 15);
            high_len = h[7:0]; low_len = l[7:0]; num_pulses = n[7:0]; start = 1'b1;
            tick(); start = 1'b0;
            p_r = rise_edge; p_f = fall_edge;
            rises = 1;
            got_done = 1'b0;
            for (int c = 0; c < 600 && !got_done; c++) begin
                tick();
                chk($sformatf("loop%0d_det_rise_%0d", t, c), {31'd0, det_rise}, {31'd0, p_r});
                chk($sformatf("loop%0d_det_fall_%0d", t, c), {31'd0, det_fall}, {31'd0, p_f});
                if (rise_edge) rises++;
                p_r = rise_edge; p_f = fall_edge;
                if (done) got_done = 1'b1;
            end
            chk($sformatf("loop%0d_done_seen", t), {31'd0, got_done}, 32'd1);
            chk($sformatf("loop%0d_rise_count", t), rises, n);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
